// File: rtl/mem_io_pkg.sv
// Shared types, encodings and lane helpers for the memory/IO bridge.
package mem_io_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned IO_OUT_OFS = 16;

  typedef enum logic [2:0] {
    StIdle,
    StMem,
    StWait,
    StIo,
    StResp
  } state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/io_sync.sv
// Two-flop synchroniser for raw board inputs, cleared on reset.
module io_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Multi-cycle load/store steering to data memory or IO channels with a
// single-outstanding valid/busy handshake; every output is registered.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] IO_BASE     = 32'hFFFF_FC00,
  parameter int unsigned       IO_W        = 16,
  parameter int unsigned       NUM_IN      = 2,
  parameter int unsigned       NUM_OUT     = 2,
  parameter int unsigned       MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    busy,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic [NUM_IN*IO_W-1:0]  io_in,
  output logic [NUM_OUT*IO_W-1:0] io_out,
  output logic [NUM_OUT-1:0]      io_out_stb
);

  localparam int unsigned CntW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [1:0]          lane_q;
  logic [4:0]          ofs_q;
  logic [IO_W-1:0]     io_wdata_q;
  logic [NUM_IN*IO_W-1:0] io_in_sync;

  logic [ADDR_W-1:0]   ofs_full;
  logic                is_io;
  logic                io_ok;
  logic                out_range;
  logic                dec_err;
  logic [31:0]         io_rd;
  logic [31:0]         mem_rd;

  io_sync #(
    .WIDTH(NUM_IN * IO_W)
  ) u_io_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (io_in),
    .q    (io_in_sync)
  );

  always_comb begin
    is_io     = req_addr >= IO_BASE;
    ofs_full  = (req_addr - IO_BASE) >> 2;
    out_range = (ofs_full >= ADDR_W'(IO_OUT_OFS)) && (ofs_full < ADDR_W'(IO_OUT_OFS + NUM_OUT));
    io_ok     = req_we ? out_range : (out_range || (ofs_full < ADDR_W'(NUM_IN)));
    dec_err   = 1'b0;
    case (req_size)
      SZ_BYTE: dec_err = 1'b0;
      SZ_HALF: dec_err = req_addr[0];
      SZ_WORD: dec_err = |req_addr[1:0];
      default: dec_err = 1'b1;
    endcase
    if (is_io && ((req_size != SZ_WORD) || !io_ok)) begin
      dec_err = 1'b1;
    end
  end

  always_comb begin
    io_rd = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (ofs_q == 5'(k)) io_rd = 32'(io_in_sync[k*IO_W +: IO_W]);
    end
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (ofs_q == 5'(IO_OUT_OFS + k)) io_rd = 32'(io_out[k*IO_W +: IO_W]);
    end
    mem_rd = we_q ? 32'h0 : load_extract(mem_rdata, lane_q, size_q, uns_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      ofs_q      <= '0;
      io_wdata_q <= '0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      io_out     <= '0;
      io_out_stb <= '0;
    end else begin
      mem_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      io_out_stb <= '0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            busy       <= 1'b1;
            we_q       <= req_we;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            lane_q     <= req_addr[1:0];
            ofs_q      <= ofs_full[4:0];
            io_wdata_q <= req_wdata[IO_W-1:0];
            if (dec_err) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (is_io) begin
              state_q <= StIo;
            end else begin
              state_q   <= StMem;
              mem_en    <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= byte_en(req_size, req_addr[1:0]);
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= replicate(req_size, req_wdata);
            end
          end
        end
        StMem: begin
          if (MEM_LATENCY == 1) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_rd;
          end else begin
            state_q <= StWait;
            cnt_q   <= CntW'(MEM_LATENCY - 2);
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_rd;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StIo: begin
          state_q   <= StResp;
          rsp_valid <= 1'b1;
          rsp_rdata <= we_q ? 32'h0 : io_rd;
          if (we_q) begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
              if (ofs_q == 5'(IO_OUT_OFS + k)) begin
                io_out[k*IO_W +: IO_W] <= io_wdata_q;
                io_out_stb[k]          <= 1'b1;
              end
            end
          end
        end
        StResp: begin
          state_q   <= StIdle;
          busy      <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench: default-latency bridge plus a MEM_LATENCY=3 instance.
module tb_mem_io_bridge;
  import mem_io_pkg::*;

  localparam logic [31:0] IOB = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid3 = 1'b0;
  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0, io_in = '0;

  logic        busy, rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, io_out;
  logic [3:0]  mem_be;
  logic [1:0]  io_out_stb;
  logic        busy3, rsp_valid3, rsp_err3, mem_en3, mem_we3;
  logic [31:0] rsp_rdata3, mem_addr3, mem_wdata3, io_out3;
  logic [3:0]  mem_be3;
  logic [1:0]  io_out_stb3;

  int checks = 0;
  int failures = 0;
  logic seen;

  always #5 clk = ~clk;

  mem_io_bridge #(.MEM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .io_in(io_in), .io_out(io_out), .io_out_stb(io_out_stb)
  );

  mem_io_bridge #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .mem_en(mem_en3),
    .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata), .io_in(io_in), .io_out(io_out3), .io_out_stb(io_out_stb3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge (cycle T); returns on the falling edge of T+1.
  task automatic issue(input logic sel3, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (sel3) req_valid3 = 1'b1;
    else req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_valid3 = 1'b0;
  endtask

  task automatic watch_quiet3(input string tag);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid3 || mem_en3) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_io_out", io_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte store to lane 3
    issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0000_00AB);
    check("sb_mem_en", 32'(mem_en), 32'h1);
    check("sb_mem_we", 32'(mem_we), 32'h1);
    check("sb_mem_be", 32'(mem_be), 32'h8);
    check("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_mem_addr", mem_addr, 32'h0000_0100);
    check("sb_busy", 32'(busy), 32'h1);
    check("sb_rsp_early", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check("sb_rsp_valid", 32'(rsp_valid), 32'h1);
    check("sb_rsp_rdata", rsp_rdata, 32'h0);
    check("sb_mem_en_once", 32'(mem_en), 32'h0);
    @(negedge clk);
    check("sb_rsp_pulse", 32'(rsp_valid), 32'h0);
    check("sb_idle", 32'(busy), 32'h0);

    // Half store to upper half
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0102, 32'h1234_CDEF);
    check("sh_mem_be", 32'(mem_be), 32'hC);
    check("sh_mem_wdata", mem_wdata, 32'hCDEF_CDEF);
    @(negedge clk);
    @(negedge clk);

    // Byte loads, signed and unsigned
    mem_rdata = 32'h1280_3456;
    issue(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0102, 32'h0);
    check("lb_mem_be", 32'(mem_be), 32'h4);
    check("lb_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    check("lb_rsp_valid", 32'(rsp_valid), 32'h1);
    check("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    @(negedge clk);
    issue(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0102, 32'h0);
    @(negedge clk);
    check("lbu_rdata", rsp_rdata, 32'h0000_0080);
    @(negedge clk);

    // Half and word loads
    mem_rdata = 32'h8001_7FFF;
    issue(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h0000_0102, 32'h0);
    @(negedge clk);
    check("lh_hi_rdata", rsp_rdata, 32'hFFFF_8001);
    @(negedge clk);
    issue(1'b0, 1'b0, SZ_HALF, 1'b1, 32'h0000_0102, 32'h0);
    @(negedge clk);
    check("lhu_hi_rdata", rsp_rdata, 32'h0000_8001);
    @(negedge clk);
    issue(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    check("lh_lo_rdata", rsp_rdata, 32'h0000_7FFF);
    @(negedge clk);
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0);
    check("lw_mem_be", 32'(mem_be), 32'hF);
    check("lw_mem_addr", mem_addr, 32'h0000_0104);
    @(negedge clk);
    check("lw_rdata", rsp_rdata, 32'h8001_7FFF);
    @(negedge clk);

    // Latency 3: response in T+4
    mem_rdata = 32'h1280_3456;
    issue(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0102, 32'h0);
    check("l3_mem_en", 32'(mem_en3), 32'h1);
    @(negedge clk);
    check("l3_mem_en_once", 32'(mem_en3), 32'h0);
    check("l3_rsp_t2", 32'(rsp_valid3), 32'h0);
    @(negedge clk);
    check("l3_rsp_t3", 32'(rsp_valid3), 32'h0);
    check("l3_busy_t3", 32'(busy3), 32'h1);
    @(negedge clk);
    check("l3_rsp_t4", 32'(rsp_valid3), 32'h1);
    check("l3_rdata", rsp_rdata3, 32'hFFFF_FF80);
    @(negedge clk);

    // IO write to output channel 0, then readback
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, IOB + 32'h40, 32'h0000_5A5A);
    check("iow_no_mem_en", 32'(mem_en), 32'h0);
    check("iow_stb_t1", 32'(io_out_stb), 32'h0);
    @(negedge clk);
    check("iow_rsp_valid", 32'(rsp_valid), 32'h1);
    check("iow_io_out", io_out, 32'h0000_5A5A);
    check("iow_stb", 32'(io_out_stb), 32'h1);
    @(negedge clk);
    check("iow_stb_pulse", 32'(io_out_stb), 32'h0);
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, IOB + 32'h40, 32'h0);
    @(negedge clk);
    check("ior_readback", rsp_rdata, 32'h0000_5A5A);
    @(negedge clk);

    // Input channel 1 through the synchroniser
    io_in = 32'hBEEF_0000;
    repeat (3) @(negedge clk);
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, IOB + 32'h4, 32'h0);
    @(negedge clk);
    check("ior_in1", rsp_rdata, 32'h0000_BEEF);
    @(negedge clk);
    io_in = 32'h1111_0000;
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, IOB + 32'h4, 32'h0);
    @(negedge clk);
    check("ior_in1_stale", rsp_rdata, 32'h0000_BEEF);
    @(negedge clk);
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, IOB + 32'h4, 32'h0);
    @(negedge clk);
    check("ior_in1_new", rsp_rdata, 32'h0000_1111);
    @(negedge clk);

    // Errors: misaligned half, illegal size, byte IO, IO write below 16, IO offset out of range
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0101, 32'hFFFF_FFFF);
    check("e_half_err", 32'({rsp_valid, rsp_err}), 32'h3);
    check("e_half_no_mem", 32'(mem_en), 32'h0);
    @(negedge clk);
    issue(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
    check("e_size_err", 32'({rsp_valid, rsp_err}), 32'h3);
    check("e_size_no_mem", 32'(mem_en), 32'h0);
    check("e_size_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    issue(1'b0, 1'b1, SZ_BYTE, 1'b0, IOB + 32'h40, 32'h0000_00FF);
    check("e_iobyte_err", 32'({rsp_valid, rsp_err}), 32'h3);
    check("e_iobyte_stb", 32'(io_out_stb), 32'h0);
    @(negedge clk);
    check("e_iobyte_stb2", 32'(io_out_stb), 32'h0);
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, IOB, 32'h0000_1234);
    check("e_iow0_err", 32'({rsp_valid, rsp_err}), 32'h3);
    @(negedge clk);
    check("e_iow0_stb", 32'(io_out_stb), 32'h0);
    check("e_io_out_kept", io_out, 32'h0000_5A5A);
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, IOB + 32'h48, 32'h0);
    check("e_ofs_err", 32'({rsp_valid, rsp_err}), 32'h3);
    @(negedge clk);

    // Reset during MEM (latency 3 instance)
    issue(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0102, 32'h0);
    check("rm_mem_en", 32'(mem_en3), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rm_busy", 32'(busy3), 32'h0);
    check("rm_mem_en_clr", 32'(mem_en3), 32'h0);
    check("rm_mem_be_clr", 32'(mem_be3), 32'h0);
    check("rm_mem_addr_clr", mem_addr3, 32'h0);
    check("rm_io_out_clr", io_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet3("rm_no_rsp");

    // Reset during WAIT
    issue(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0102, 32'h0);
    @(negedge clk);
    check("rw_in_wait", 32'({busy3, mem_en3}), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("rw_busy", 32'(busy3), 32'h0);
    check("rw_rsp", 32'(rsp_valid3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet3("rw_no_rsp");

    // Fresh request completes normally after reset
    issue(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0102, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rr_rsp_t3", 32'(rsp_valid3), 32'h0);
    @(negedge clk);
    check("rr_rsp_t4", 32'(rsp_valid3), 32'h1);
    check("rr_rdata", rsp_rdata3, 32'h0000_0080);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
